instruction_fetch: RTL and testbench

- IF stage of the five-stage pipelined ARMv8 core; sits directly upstream of instruction decode.
- Holds the PC and issues one 32-bit fetch per cycle over a ready-handshake instruction-memory port.
- Produces the IF/ID pipeline register (instruction, PC, PC+4, valid) that decode reads.
- Handles hazard stalls with a one-entry skid buffer, plus branch redirect and flush.

---
 rtl/instruction_fetch_pkg.sv | 20 ++
 rtl/instruction_fetch_if_id_register.sv | 39 +++
 rtl/instruction_fetch.sv | 125 ++++++++++++
 tb/tb_instruction_fetch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared core definitions for the IF stage: datapath widths, the bubble
// encoding and the fetch FSM state encoding.
package instruction_fetch_pkg;

    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;

    // ARMv8 NOP, injected into IF/ID whenever the stage emits a bubble.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

    typedef enum logic {
        FETCH    = 1'b0,
        BUFFERED = 1'b1
    } fetch_state_t;

    function automatic logic [XLEN-1:0] pc_increment(input logic [XLEN-1:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: load a new entry, hold it, or turn it into a
// bubble (valid cleared, NOP instruction, PC fields kept).
module if_id_register
    import instruction_fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = 32'hD503201F
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] d_instruction,
    input  logic [XLEN-1:0]    d_pc,
    input  logic [XLEN-1:0]    d_pc_plus4,
    output logic [INSTR_W-1:0] q_instruction,
    output logic [XLEN-1:0]    q_pc,
    output logic [XLEN-1:0]    q_pc_plus4,
    output logic               q_valid
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_instruction <= BUBBLE_INSTR;
            q_pc          <= '0;
            q_pc_plus4    <= '0;
            q_valid       <= 1'b0;
        end else if (bubble) begin
            // PC fields deliberately untouched so decode sees a stable address.
            q_instruction <= BUBBLE_INSTR;
            q_valid       <= 1'b0;
        end else if (load) begin
            q_instruction <= d_instruction;
            q_pc          <= d_pc;
            q_pc_plus4    <= d_pc_plus4;
            q_valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, issues one fetch per cycle and feeds IF/ID, with a
// one-entry skid buffer that catches a fetch completing under a stall.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_WORD  = 32'hD503201F
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        PCSrc,
    input  logic [63:0] branch_target,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    output logic [31:0] if_id_instruction,
    output logic [63:0] if_id_pc,
    output logic [63:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    fetch_state_t       state_reg, state_next;
    logic [XLEN-1:0]    pc_reg, pc_next;
    logic [INSTR_W-1:0] skid_instr_reg, skid_instr_next;
    logic [XLEN-1:0]    skid_pc_reg, skid_pc_next;

    logic               ifid_load, ifid_bubble;
    logic [INSTR_W-1:0] ifid_instr_d;
    logic [XLEN-1:0]    ifid_pc_d;
    logic               fire;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    redirect_pc;

    assign imem_addr   = pc_reg;
    assign imem_req    = (state_reg == FETCH) && !reset;
    assign fire        = imem_req && imem_ready;
    assign pc_plus4    = pc_increment(pc_reg);
    assign redirect_pc = {branch_target[63:2], 2'b00};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= FETCH;
            pc_reg         <= RESET_PC;
            skid_instr_reg <= NOP_WORD;
            skid_pc_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc_reg    <= skid_pc_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc_next    = skid_pc_reg;
        ifid_load       = 1'b0;
        ifid_bubble     = 1'b0;
        ifid_instr_d    = imem_rdata;
        ifid_pc_d       = pc_reg;

        case (state_reg)
            FETCH: begin
                if (PCSrc) begin
                    pc_next     = redirect_pc;
                    ifid_bubble = 1'b1;
                end else if (flush) begin
                    ifid_bubble = 1'b1;
                    if (fire) pc_next = pc_plus4;
                end else if (stall) begin
                    // A word arriving under a stall is parked, never refetched.
                    if (fire) begin
                        skid_instr_next = imem_rdata;
                        skid_pc_next    = pc_reg;
                        pc_next         = pc_plus4;
                        state_next      = BUFFERED;
                    end
                end else if (fire) begin
                    ifid_load = 1'b1;
                    pc_next   = pc_plus4;
                end else begin
                    ifid_bubble = 1'b1;
                end
            end
            BUFFERED: begin
                ifid_instr_d = skid_instr_reg;
                ifid_pc_d    = skid_pc_reg;
                if (PCSrc) begin
                    pc_next     = redirect_pc;
                    ifid_bubble = 1'b1;
                    state_next  = FETCH;
                end else if (flush) begin
                    ifid_bubble = 1'b1;
                    state_next  = FETCH;
                end else if (!stall) begin
                    ifid_load  = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    if_id_register #(
        .BUBBLE_INSTR(NOP_WORD)
    ) u_if_id (
        .clock         (clock),
        .reset         (reset),
        .load          (ifid_load),
        .bubble        (ifid_bubble),
        .d_instruction (ifid_instr_d),
        .d_pc          (ifid_pc_d),
        .d_pc_plus4    (pc_increment(ifid_pc_d)),
        .q_instruction (if_id_instruction),
        .q_pc          (if_id_pc),
        .q_pc_plus4    (if_id_pc_plus4),
        .q_valid       (if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for the IF stage: address-tagged memory model and
// hand-computed IF/ID contents checked one edge at a time.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        PCSrc = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] if_id_instruction;
    logic [63:0] if_id_pc;
    logic [63:0] if_id_pc_plus4;
    logic        if_id_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] tag(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = tag(imem_addr);

    logic [160:0] ifid_obs;
    logic [64:0]  mem_obs;
    assign ifid_obs = {if_id_valid, if_id_instruction, if_id_pc, if_id_pc_plus4};
    assign mem_obs  = {imem_req, imem_addr};

    instruction_fetch #(.RESET_PC(64'h0), .NOP_WORD(NOP)) dut (
        .clock             (clock),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .PCSrc             (PCSrc),
        .branch_target     (branch_target),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .if_id_instruction (if_id_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [160:0] exp_ifid;
        exp_ifid = {1'b0, NOP, 64'd0, 64'd0};
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (ifid_obs !== exp_ifid) begin
            n_fail++;
            $display("FAIL reset_ifid: got %h want %h", ifid_obs, exp_ifid);
        end
        n_checks++;
        if (mem_obs !== {1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_mem: got %h want %h", mem_obs, {1'b0, 64'd0});
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (mem_obs !== {1'b1, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_release_req: got %h want %h", mem_obs, {1'b1, 64'd0});
        end
        $display("txn reset: ifid=%h mem=%h", ifid_obs, mem_obs);
    endtask

    task automatic test_sequential();
        logic [63:0] a;
        for (int i = 0; i < 2; i++) begin
            a = 64'(i * 4);
            step();
            n_checks++;
            if (ifid_obs !== {1'b1, tag(a), a, a + 64'd4}) begin
                n_fail++;
                $display("FAIL seq_pc%0d: got %h want %h", i * 4, ifid_obs, {1'b1, tag(a), a, a + 64'd4});
            end
            $display("txn seq: if_id_pc=%h instr=%h", if_id_pc, if_id_instruction);
        end
    endtask

    task automatic test_mem_wait();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (ifid_obs !== {1'b0, NOP, 64'd4, 64'd8} || mem_obs !== {1'b1, 64'd8}) begin
                n_fail++;
                $display("FAIL wait_bubble%0d: got %h/%h want %h/%h", i, ifid_obs, mem_obs,
                         {1'b0, NOP, 64'd4, 64'd8}, {1'b1, 64'd8});
            end
            $display("txn wait: valid=%b addr=%h", if_id_valid, imem_addr);
        end
        imem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (ifid_obs !== {1'b1, tag(64'(8 + 4 * i)), 64'(8 + 4 * i), 64'(12 + 4 * i)}) begin
                n_fail++;
                $display("FAIL wait_resume%0d: got %h want %h", i, ifid_obs,
                         {1'b1, tag(64'(8 + 4 * i)), 64'(8 + 4 * i), 64'(12 + 4 * i)});
            end
            $display("txn resume: if_id_pc=%h", if_id_pc);
        end
    endtask

    task automatic test_stall_completion();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (ifid_obs !== {1'b1, tag(64'd12), 64'd12, 64'd16} || mem_obs !== {1'b0, 64'd20}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got %h/%h want %h/%h", i, ifid_obs, mem_obs,
                         {1'b1, tag(64'd12), 64'd12, 64'd16}, {1'b0, 64'd20});
            end
            $display("txn stall: if_id_pc=%h req=%b addr=%h", if_id_pc, imem_req, imem_addr);
        end
        stall = 1'b0;
        step();
        n_checks++;
        if (ifid_obs !== {1'b1, tag(64'd16), 64'd16, 64'd20} || mem_obs !== {1'b1, 64'd20}) begin
            n_fail++;
            $display("FAIL stall_drain: got %h/%h want %h/%h", ifid_obs, mem_obs,
                     {1'b1, tag(64'd16), 64'd16, 64'd20}, {1'b1, 64'd20});
        end
        step();
        n_checks++;
        if (ifid_obs !== {1'b1, tag(64'd20), 64'd20, 64'd24}) begin
            n_fail++;
            $display("FAIL stall_next: got %h want %h", ifid_obs, {1'b1, tag(64'd20), 64'd20, 64'd24});
        end
        $display("txn drain: if_id_pc=%h", if_id_pc);
    endtask

    task automatic test_flush_vs_redirect();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if (ifid_obs !== {1'b0, NOP, 64'd20, 64'd24} || mem_obs !== {1'b1, 64'd28}) begin
            n_fail++;
            $display("FAIL flush_alone: got %h/%h want %h/%h", ifid_obs, mem_obs,
                     {1'b0, NOP, 64'd20, 64'd24}, {1'b1, 64'd28});
        end
        $display("txn flush: valid=%b addr=%h", if_id_valid, imem_addr);
        PCSrc = 1'b1;
        stall = 1'b1;
        branch_target = 64'h2002;
        step();
        PCSrc = 1'b0;
        stall = 1'b0;
        n_checks++;
        if (ifid_obs !== {1'b0, NOP, 64'd20, 64'd24} || mem_obs !== {1'b1, 64'h2000}) begin
            n_fail++;
            $display("FAIL pcsrc_beats_stall: got %h/%h want %h/%h", ifid_obs, mem_obs,
                     {1'b0, NOP, 64'd20, 64'd24}, {1'b1, 64'h2000});
        end
        step();
        n_checks++;
        if (ifid_obs !== {1'b1, tag(64'h2000), 64'h2000, 64'h2004}) begin
            n_fail++;
            $display("FAIL redirect_fetch: got %h want %h", ifid_obs, {1'b1, tag(64'h2000), 64'h2000, 64'h2004});
        end
        $display("txn redirect: if_id_pc=%h", if_id_pc);
    endtask

    task automatic test_branch_buffered();
        stall = 1'b1;
        step();
        n_checks++;
        if (mem_obs !== {1'b0, 64'h2008}) begin
            n_fail++;
            $display("FAIL buffered_enter: got %h want %h", mem_obs, {1'b0, 64'h2008});
        end
        PCSrc = 1'b1;
        branch_target = 64'h1003;
        step();
        PCSrc = 1'b0;
        stall = 1'b0;
        n_checks++;
        if (ifid_obs !== {1'b0, NOP, 64'h2000, 64'h2004} || mem_obs !== {1'b1, 64'h1000}) begin
            n_fail++;
            $display("FAIL branch_buffered: got %h/%h want %h/%h", ifid_obs, mem_obs,
                     {1'b0, NOP, 64'h2000, 64'h2004}, {1'b1, 64'h1000});
        end
        step();
        n_checks++;
        if (ifid_obs !== {1'b1, tag(64'h1000), 64'h1000, 64'h1004}) begin
            n_fail++;
            $display("FAIL skid_discarded: got %h want %h", ifid_obs, {1'b1, tag(64'h1000), 64'h1000, 64'h1004});
        end
        $display("txn branch_buffered: if_id_pc=%h", if_id_pc);
    endtask

    task automatic test_wrap();
        PCSrc = 1'b1;
        branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        PCSrc = 1'b0;
        step();
        n_checks++;
        if (ifid_obs !== {1'b1, tag(64'hFFFF_FFFF_FFFF_FFFC), 64'hFFFF_FFFF_FFFF_FFFC, 64'd0}
            || mem_obs !== {1'b1, 64'd0}) begin
            n_fail++;
            $display("FAIL wrap: got %h/%h want %h/%h", ifid_obs, mem_obs,
                     {1'b1, tag(64'hFFFF_FFFF_FFFF_FFFC), 64'hFFFF_FFFF_FFFF_FFFC, 64'd0}, {1'b1, 64'd0});
        end
        step();
        n_checks++;
        if (ifid_obs !== {1'b1, tag(64'd0), 64'd0, 64'd4}) begin
            n_fail++;
            $display("FAIL wrap_next: got %h want %h", ifid_obs, {1'b1, tag(64'd0), 64'd0, 64'd4});
        end
        $display("txn wrap: if_id_pc=%h", if_id_pc);
    endtask

    task automatic test_async_reset();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ifid_obs !== {1'b0, NOP, 64'd0, 64'd0} || mem_obs !== {1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got %h/%h want %h/%h", ifid_obs, mem_obs,
                     {1'b0, NOP, 64'd0, 64'd0}, {1'b0, 64'd0});
        end
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (ifid_obs !== {1'b1, tag(64'd0), 64'd0, 64'd4}) begin
            n_fail++;
            $display("FAIL post_reset_fetch: got %h want %h", ifid_obs, {1'b1, tag(64'd0), 64'd0, 64'd4});
        end
        $display("txn async_reset: if_id_pc=%h valid=%b", if_id_pc, if_id_valid);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_mem_wait();
        test_stall_completion();
        test_flush_vs_redirect();
        test_branch_buffered();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion want finish");
        $fatal(1, "timeout");
    end

endmodule
